// File: rtl/minibus_pkg.sv
// Purpose : shared minibus packet types, arbiter FSM encoding and constants.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: word_t, minibus_req_pack (addr, wdata, ren, wen),
//           minibus_res_pack (rdata, ready), minibus_arb_state_e,
//           MINIBUS_TIMEOUT_RDATA (read data returned on a forced completion).
package minibus_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t addr;
      word_t wdata;
      logic  ren;
      logic  wen;
   } minibus_req_pack;

   typedef struct packed {
      word_t rdata;
      logic  ready;
   } minibus_res_pack;

   typedef enum logic {ARB_IDLE, ARB_OWNED} minibus_arb_state_e;

   localparam word_t MINIBUS_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/minibus_arbiter_rr_picker.sv
// Purpose : round-robin picker, first set bit strictly after 'last', wrapping mod N.
// Latency : combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports: req_vec [N]  request bits
//        last         index of the previous winner (search starts at last+1)
//        pick         winning index (0 when nothing is valid)
//        any_valid    at least one request bit set
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_vec,
   input  logic [$clog2(N)-1:0] last,
   output logic [$clog2(N)-1:0] pick,
   output logic                 any_valid
);

   localparam int W = $clog2(N);

   logic [W-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest valid index,
   // counting forward from last+1, is the one left standing in 'pick'.
   always_comb begin
      pick      = '0;
      idx       = '0;
      any_valid = |req_vec;
      for (int off = N; off >= 1; off--) begin
         idx = W'((int'(last) + off) % N);
         if (req_vec[idx]) begin
            pick = idx;
         end
      end
   end

endmodule

// File: rtl/minibus_arbiter.sv
// Purpose : shares one minibus master port among MASTER_COUNT requesters, round-robin, grant held per transaction.
// Latency : 1 idle arbitration cycle before a grant; slave response forwarded combinationally while owned.
// Backpressure: a requester holds its packet until its m_res.ready; the grant is held until s_res.ready (or timeout).
//
// Ports: clk, rst (synchronous, active-high)
//        m_req[N] / m_res[N]  requester side packets
//        s_req / s_res        single master port toward the decoder
//        grant_id             current / last owner
//        busy                 transaction in flight
//        timeout_flag         sticky forced-completion indicator
// Optional: define MINIBUS_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES stalled cycles.
module minibus_arbiter
   import minibus_pkg::*;
#(
   parameter int MASTER_COUNT   = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                            clk,
   input  logic                            rst,
   input  minibus_req_pack                 m_req [MASTER_COUNT],
   output minibus_res_pack                 m_res [MASTER_COUNT],
   output minibus_req_pack                 s_req,
   input  minibus_res_pack                 s_res,
   output logic [$clog2(MASTER_COUNT)-1:0] grant_id,
   output logic                            busy,
   output logic                            timeout_flag
);

   localparam int GW = $clog2(MASTER_COUNT);

   if (MASTER_COUNT < 2 || MASTER_COUNT > 8) begin : g_bad_count
      $error("minibus_arbiter: MASTER_COUNT must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("minibus_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   minibus_arb_state_e state, state_nxt;
   logic [GW-1:0]      grant_q;
   logic [GW-1:0]      last_grant;
   logic [MASTER_COUNT-1:0] req_vec;
   logic [GW-1:0]      pick_idx;
   logic               pick_vld;
   logic               to_fire;
   logic               done;

   always_comb begin
      req_vec = '0;
      for (int k = 0; k < MASTER_COUNT; k++) begin
         req_vec[k] = m_req[k].ren | m_req[k].wen;
      end
   end

   rr_picker #(.N(MASTER_COUNT)) u_pick (
      .req_vec   (req_vec),
      .last      (last_grant),
      .pick      (pick_idx),
      .any_valid (pick_vld)
   );

`ifdef MINIBUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] to_cnt;
   logic          to_flag_q;

   // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES,
   // so the forced completion lands on OWNED cycle number TIMEOUT_CYCLES.
   assign to_fire = (state == ARB_OWNED) && !s_res.ready &&
                    (to_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt    <= '0;
         to_flag_q <= 1'b0;
      end else begin
         // Held at zero in IDLE, so it is already clear on entry to OWNED.
         if (state == ARB_IDLE) begin
            to_cnt <= '0;
         end else if (!s_res.ready) begin
            to_cnt <= to_cnt + CW'(1);
         end
         if (to_fire) begin
            to_flag_q <= 1'b1;
         end
      end
   end

   assign timeout_flag = to_flag_q;
`else
   assign to_fire      = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   assign done = (state == ARB_OWNED) && (s_res.ready || to_fire);

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:  if (pick_vld) state_nxt = ARB_OWNED;
         ARB_OWNED: if (done)     state_nxt = ARB_IDLE;
         default:                 state_nxt = ARB_IDLE;
      endcase
   end

   // Mux toward the slave and demux back to the owner. The response path is
   // blanked during rst so an abandoned transaction never sees a ready.
   always_comb begin
      s_req = '0;
      for (int k = 0; k < MASTER_COUNT; k++) begin
         m_res[k] = '0;
      end
      for (int k = 0; k < MASTER_COUNT; k++) begin
         if (state == ARB_OWNED && GW'(k) == grant_q) begin
            if (!to_fire) begin
               s_req = m_req[k];
            end
            if (!rst) begin
               if (to_fire) begin
                  m_res[k].rdata = MINIBUS_TIMEOUT_RDATA;
                  m_res[k].ready = 1'b1;
               end else begin
                  m_res[k] = s_res;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         grant_q    <= '0;
         last_grant <= GW'(MASTER_COUNT - 1);
      end else begin
         state <= state_nxt;
         if (state == ARB_IDLE && pick_vld) begin
            grant_q <= pick_idx;
         end
         if (done) begin
            last_grant <= grant_q;
         end
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state == ARB_OWNED);

endmodule
